// File: rtl/path_counter.sv
// path_counter: counts distinct start->end paths in a DAG by
// stack-driven depth-first traversal over a query/reply responder.
module path_counter #(
    parameter int MAX_NODES   = 1024,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int STACK_DEPTH = 512,
    parameter int COUNT_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NODE_WIDTH-1:0]  start_node,
    input  logic [NODE_WIDTH-1:0]  end_node,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] path_count,
    output logic                   count_saturated,
    output logic                   stack_overflow,
    input  logic                   query_ready,
    output logic                   query_valid,
    output logic [NODE_WIDTH-1:0]  query_data,
    input  logic                   reply_valid,
    output logic                   reply_ready,
    input  logic [NODE_WIDTH-1:0]  reply_data,
    input  logic                   reply_last,
    input  logic                   reply_no_edges_found
);

    localparam int SP_WIDTH  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_WIDTH = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_QUERY,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SP_WIDTH-1:0]    sp_q, sp_d;
    logic [SP_WIDTH-1:0]    sp_m1;
    logic [NODE_WIDTH-1:0]  stack_mem [STACK_DEPTH];
    logic [NODE_WIDTH-1:0]  top;
    logic [NODE_WIDTH-1:0]  cur_q, cur_d;
    logic [NODE_WIDTH-1:0]  end_q, end_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   ovf_q, ovf_d;
    logic                   push;
    logic [IDX_WIDTH-1:0]   push_idx;
    logic [NODE_WIDTH-1:0]  push_data;
    logic                   stack_full;

    assign sp_m1      = sp_q - SP_WIDTH'(1);
    assign top        = stack_mem[sp_m1[IDX_WIDTH-1:0]];
    assign stack_full = (sp_q == SP_WIDTH'(STACK_DEPTH));

    assign path_count      = count_q;
    assign count_saturated = sat_q;
    assign stack_overflow  = ovf_q;
    assign query_data      = cur_q;

    // Next-state, stack/count updates and handshake outputs per FSM state
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        cur_d       = cur_q;
        end_d       = end_q;
        count_d     = count_q;
        sat_d       = sat_q;
        ovf_d       = ovf_q;
        push        = 1'b0;
        push_idx    = sp_q[IDX_WIDTH-1:0];
        push_data   = reply_data;
        busy        = 1'b0;
        done        = 1'b0;
        query_valid = 1'b0;
        reply_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    end_d     = end_node;
                    count_d   = '0;
                    sat_d     = 1'b0;
                    ovf_d     = 1'b0;
                    push      = 1'b1;
                    push_idx  = '0;
                    push_data = start_node;
                    sp_d      = SP_WIDTH'(1);
                    state_d   = S_POP;
                end
            end
            S_POP: begin
                busy = 1'b1;
                if (sp_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    sp_d = sp_m1;
                    if (top == end_q) begin
                        // the target is counted, never expanded
                        if (&count_q) sat_d = 1'b1;
                        else count_d = count_q + COUNT_WIDTH'(1);
                    end else begin
                        cur_d   = top;
                        state_d = S_QUERY;
                    end
                end
            end
            S_QUERY: begin
                busy        = 1'b1;
                query_valid = query_ready;
                if (query_ready) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                busy        = 1'b1;
                reply_ready = 1'b1;
                if (reply_valid) begin
                    if (!reply_no_edges_found) begin
                        // a full stack drops the successor but keeps going
                        if (stack_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SP_WIDTH'(1);
                        end
                    end
                    if (reply_last) state_d = S_POP;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset discards any run in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            cur_q   <= '0;
            end_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stack storage; contents are only meaningful below the pointer
    always_ff @(posedge clk) begin
        if (push) stack_mem[push_idx] <= push_data;
    end

endmodule

// File: tb/tb_path_counter.sv
// tb_path_counter: table vectors, reset corner case and random DAGs
// checked against a path-enumeration model of the traversal.
module tb_path_counter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       go   [3];
    logic [9:0] sn   [3];
    logic [9:0] en   [3];
    logic       by   [3];
    logic       dn   [3];
    logic       sat  [3];
    logic       ovf  [3];
    logic       qr   [3];
    logic       qv   [3];
    logic [9:0] qd   [3];
    logic       rv   [3];
    logic       rr   [3];
    logic [9:0] rd   [3];
    logic       rl   [3];
    logic       rn   [3];
    logic [47:0] pc0, pc1;
    logic [1:0]  pc2;

    path_counter u0 (
        .clk(clk), .reset(reset), .start(go[0]),
        .start_node(sn[0]), .end_node(en[0]),
        .busy(by[0]), .done(dn[0]), .path_count(pc0),
        .count_saturated(sat[0]), .stack_overflow(ovf[0]),
        .query_ready(qr[0]), .query_valid(qv[0]),
        .query_data(qd[0]), .reply_valid(rv[0]),
        .reply_ready(rr[0]), .reply_data(rd[0]),
        .reply_last(rl[0]), .reply_no_edges_found(rn[0])
    );

    path_counter #(.STACK_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .start(go[1]),
        .start_node(sn[1]), .end_node(en[1]),
        .busy(by[1]), .done(dn[1]), .path_count(pc1),
        .count_saturated(sat[1]), .stack_overflow(ovf[1]),
        .query_ready(qr[1]), .query_valid(qv[1]),
        .query_data(qd[1]), .reply_valid(rv[1]),
        .reply_ready(rr[1]), .reply_data(rd[1]),
        .reply_last(rl[1]), .reply_no_edges_found(rn[1])
    );

    path_counter #(.COUNT_WIDTH(2)) u2 (
        .clk(clk), .reset(reset), .start(go[2]),
        .start_node(sn[2]), .end_node(en[2]),
        .busy(by[2]), .done(dn[2]), .path_count(pc2),
        .count_saturated(sat[2]), .stack_overflow(ovf[2]),
        .query_ready(qr[2]), .query_valid(qv[2]),
        .query_data(qd[2]), .reply_valid(rv[2]),
        .reply_ready(rr[2]), .reply_data(rd[2]),
        .reply_last(rl[2]), .reply_no_edges_found(rn[2])
    );

    int passed = 0;
    int total  = 0;

    int         adj_n [1024];
    logic [9:0] adj_d [1024][8];

    typedef struct {
        int     ch;
        int     gid;
        int     s;
        int     e;
        longint cnt;
        bit     sat;
        bit     ovf;
        int     nq;
        int     dcyc;
    } vec_t;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [47:0] pc_of(input int ch);
        if (ch == 0) return pc0;
        if (ch == 1) return pc1;
        return {46'd0, pc2};
    endfunction

    task automatic clear_graph();
        for (int i = 0; i < 1024; i++) adj_n[i] = 0;
    endtask

    task automatic add(input int a, input int b);
        if (adj_n[a] < 8) begin
            adj_d[a][adj_n[a]] = 10'(b);
            adj_n[a]++;
        end
    endtask

    task automatic build(input int gid);
        clear_graph();
        case (gid)
            1: begin
                add(0, 1); add(0, 2); add(1, 3);
                add(2, 3); add(2, 1);
            end
            3: add(0, 1);
            4: for (int i = 1; i <= 6; i++) add(0, i);
            5: for (int i = 1; i <= 5; i++) begin
                add(0, i); add(i, 6);
            end
            6: for (int i = 1; i <= 4; i++) add(0, i);
            default: ;
        endcase
    endtask

    // paths: number of distinct routes to e; vis: expanded pops
    task automatic model(input int s, input int e,
                         output longint p, output longint v);
        longint pp [1024];
        longint vv [1024];
        for (int n = 0; n < 1024; n++) begin
            pp[n] = 0; vv[n] = 0;
        end
        for (int it = 0; it < 16; it++) begin
            for (int n = 0; n < 1024; n++) begin
                if (n == e) begin
                    pp[n] = 1; vv[n] = 0;
                end else begin
                    longint sp, sv;
                    sp = 0; sv = 1;
                    for (int k = 0; k < adj_n[n]; k++) begin
                        sp += pp[adj_d[n][k]];
                        sv += vv[adj_d[n][k]];
                    end
                    pp[n] = sp; vv[n] = sv;
                end
            end
        end
        p = pp[s];
        v = vv[s];
    endtask

    task automatic run(input int ch, input int s, input int e,
                       input bit abort_c, output int cyc_done,
                       output int nq, output int ndone,
                       output int bad, output bit tmo);
        logic [9:0] bq [$];
        bit         bn [$];
        int         cyc;
        bit         fin;
        nq = 0; ndone = 0; bad = 0; cyc_done = -1;
        tmo = 0; fin = 0; cyc = 0;
        sn[ch] = 10'(s);
        en[ch] = 10'(e);
        go[ch] = 1'b1;
        while (!fin) begin
            @(posedge clk);
            #1;
            go[ch] = 1'b0;
            cyc++;
            qr[ch] = ($urandom_range(0, 3) != 0);
            if (bq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rv[ch] = 1'b1;
                rd[ch] = bq[0];
                rl[ch] = (bq.size() == 1);
                rn[ch] = bn[0];
            end else begin
                rv[ch] = 1'b0;
                rd[ch] = 10'($urandom);
                rl[ch] = 1'($urandom);
                rn[ch] = 1'($urandom);
            end
            @(negedge clk);
            if (qv[ch] && !qr[ch]) bad++;
            if (qv[ch] && qr[ch]) begin
                nq++;
                if (adj_n[qd[ch]] == 0) begin
                    bq.push_back(10'($urandom));
                    bn.push_back(1'b1);
                end else begin
                    for (int k = 0; k < adj_n[qd[ch]]; k++) begin
                        bq.push_back(adj_d[qd[ch]][k]);
                        bn.push_back(1'b0);
                    end
                end
            end
            if (rv[ch] && rr[ch]) begin
                void'(bq.pop_front());
                void'(bn.pop_front());
            end
            if (dn[ch]) begin
                ndone++;
                if (cyc_done < 0) cyc_done = cyc;
                if (by[ch]) bad++;
            end else if (cyc_done < 0 && !by[ch]) begin
                bad++;
            end
            if (abort_c && rr[ch] && pc_of(ch) != 0) fin = 1;
            if (cyc_done >= 0 && cyc >= cyc_done + 3) fin = 1;
            if (cyc > 20000) begin
                tmo = 1; fin = 1;
            end
        end
        qr[ch] = 1'b0;
        rv[ch] = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s busy%0d", tag, c), by[c], 0);
            chk($sformatf("%s done%0d", tag, c), dn[c], 0);
            chk($sformatf("%s qv%0d", tag, c), qv[c], 0);
            chk($sformatf("%s rr%0d", tag, c), rr[c], 0);
            chk($sformatf("%s sat%0d", tag, c), sat[c], 0);
            chk($sformatf("%s ovf%0d", tag, c), ovf[c], 0);
            chk($sformatf("%s cnt%0d", tag, c), pc_of(c), 0);
        end
    endtask

    vec_t vecs [8];

    initial begin
        int     cd, nq, nd, bad;
        bit     tmo;
        longint p, v;

        vecs[0] = '{0, 1, 0, 3, 3, 0, 0, 4, -1};
        vecs[1] = '{0, 2, 5, 5, 1, 0, 0, 0, 3};
        vecs[2] = '{0, 3, 0, 7, 0, 0, 0, 2, -1};
        vecs[3] = '{1, 4, 0, 9, 0, 0, 1, 5, -1};
        vecs[4] = '{1, 6, 0, 9, 0, 0, 0, 5, -1};
        vecs[5] = '{1, 1, 0, 3, 3, 0, 0, 4, -1};
        vecs[6] = '{2, 5, 0, 6, 3, 1, 0, 6, -1};
        vecs[7] = '{2, 1, 0, 3, 3, 0, 0, 4, -1};

        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            go[c] = 0; sn[c] = 0; en[c] = 0; qr[c] = 1;
            rv[c] = 0; rd[c] = 0; rl[c] = 0; rn[c] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        for (int c = 0; c < 3; c++) qr[c] = 0;
        @(negedge clk);

        foreach (vecs[i]) begin
            build(vecs[i].gid);
            run(vecs[i].ch, vecs[i].s, vecs[i].e, 0,
                cd, nq, nd, bad, tmo);
            chk($sformatf("v%0d timeout", i), tmo, 0);
            chk($sformatf("v%0d count", i),
                pc_of(vecs[i].ch), vecs[i].cnt);
            chk($sformatf("v%0d sat", i), sat[vecs[i].ch], vecs[i].sat);
            chk($sformatf("v%0d ovf", i), ovf[vecs[i].ch], vecs[i].ovf);
            chk($sformatf("v%0d queries", i), nq, vecs[i].nq);
            chk($sformatf("v%0d done pulses", i), nd, 1);
            chk($sformatf("v%0d handshake", i), bad, 0);
            if (vecs[i].dcyc >= 0)
                chk($sformatf("v%0d latency", i), cd, vecs[i].dcyc);
        end

        build(1);
        run(0, 0, 3, 1, cd, nq, nd, bad, tmo);
        chk("abort timeout", tmo, 0);
        reset = 1'b1;
        qr[0] = 1'b1;
        rv[0] = 1'b1;
        #1;
        chk_reset("midrun async");
        @(posedge clk);
        @(negedge clk);
        chk_reset("midrun held");
        reset = 1'b0;
        qr[0] = 1'b0;
        rv[0] = 1'b0;
        @(negedge clk);
        run(0, 0, 3, 0, cd, nq, nd, bad, tmo);
        chk("rerun timeout", tmo, 0);
        chk("rerun count", pc_of(0), 3);
        chk("rerun done pulses", nd, 1);

        for (int r = 0; r < 24; r++) begin
            int     off, ch, s, e, nn;
            longint ec;
            bit     es;
            off = $urandom_range(0, 1023);
            nn  = 8;
            ch  = (r % 3 == 2) ? 2 : 0;
            clear_graph();
            for (int i = 0; i < nn - 1; i++) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++)
                    add((i * 97 + off) % 1024,
                        ($urandom_range(i + 1, nn - 1) * 97 + off) % 1024);
            end
            s = off;
            if (r % 5 == 4) e = (off + 1) % 1024;
            else e = ($urandom_range(1, nn - 1) * 97 + off) % 1024;
            model(s, e, p, v);
            ec = p;
            es = 0;
            if (ch == 2 && p > 3) begin
                ec = 3; es = 1;
            end
            run(ch, s, e, 0, cd, nq, nd, bad, tmo);
            chk($sformatf("rnd%0d timeout", r), tmo, 0);
            chk($sformatf("rnd%0d count", r), pc_of(ch), ec);
            chk($sformatf("rnd%0d sat", r), sat[ch], es);
            chk($sformatf("rnd%0d ovf", r), ovf[ch], 0);
            chk($sformatf("rnd%0d queries", r), nq, v);
            chk($sformatf("rnd%0d done pulses", r), nd, 1);
            chk($sformatf("rnd%0d handshake", r), bad, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
